// File: rtl/switch_step_conditioner.sv
// ---------------------------------------------------------------------------
// switch_step_conditioner
//
// Turns a raw, bouncing push-button level into clean single-cycle step
// events for the digit counter. The pad input is synchronised, debounced,
// and converted into press/release pulses. While the button stays held and
// auto-repeat is enabled, repeat pulses are added. o_Step is the combined
// increment strobe for the consumer.
//
// Ports:
//   i_Clk        system clock, rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_Switch     raw asynchronous switch level (1 = pressed)
//   i_Repeat_En  1 = auto-repeat allowed while held (synchronous)
//   o_Switch     debounced level
//   o_Press      one-cycle pulse on accepted press
//   o_Release    one-cycle pulse on accepted release
//   o_Repeat     one-cycle auto-repeat pulse
//   o_Step       o_Press | o_Repeat, registered
// ---------------------------------------------------------------------------
module switch_step_conditioner #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 12500000,
  parameter int REPEAT_LIMIT   = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  input  logic i_Repeat_En,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat,
  output logic o_Step
);

  localparam int DB_W   = $clog2(DEBOUNCE_LIMIT);
  localparam int HOLD_W = $clog2(HOLD_LIMIT);
  localparam int REP_W  = $clog2(REPEAT_LIMIT);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT - 1);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_LIMIT - 1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } state_t;

  logic              switch_meta;
  logic              switch_sync;
  logic [DB_W-1:0]   db_count;
  logic              rise;
  logic              fall;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_count;
  logic [HOLD_W-1:0] hold_next;
  logic [REP_W-1:0]  rep_count;
  logic [REP_W-1:0]  rep_next;
  logic              press_next;
  logic              release_next;
  logic              repeat_next;

  // Two-flop synchroniser and debounce counter. Any cycle where the synced
  // level agrees with the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_LIMIT mismatching cycles changes o_Switch.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      switch_meta <= 1'b0;
      switch_sync <= 1'b0;
      o_Switch    <= 1'b0;
      db_count    <= '0;
    end else begin
      switch_meta <= i_Switch;
      switch_sync <= switch_meta;
      if (switch_sync != o_Switch) begin
        if (db_count == DB_MAX) begin
          o_Switch <= switch_sync;
          db_count <= '0;
        end else begin
          db_count <= db_count + DB_W'(1);
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  // Acceptance events, true on the same edge that updates o_Switch, so the
  // press/release pulses appear in the same cycle as the new level.
  assign rise = switch_sync & ~o_Switch & (db_count == DB_MAX);
  assign fall = ~switch_sync & o_Switch & (db_count == DB_MAX);

  // State, counters and all pulse outputs are registered together.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= RELEASED;
      hold_count <= '0;
      rep_count  <= '0;
      o_Press    <= 1'b0;
      o_Release  <= 1'b0;
      o_Repeat   <= 1'b0;
      o_Step     <= 1'b0;
    end else begin
      state      <= state_next;
      hold_count <= hold_next;
      rep_count  <= rep_next;
      o_Press    <= press_next;
      o_Release  <= release_next;
      o_Repeat   <= repeat_next;
      o_Step     <= press_next | repeat_next;
    end
  end

  // Next-state logic. A release overrides everything, including a repeat
  // that happens to fall due on the same edge.
  always_comb begin
    state_next   = state;
    hold_next    = hold_count;
    rep_next     = rep_count;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;

    if (fall) begin
      state_next   = RELEASED;
      hold_next    = '0;
      rep_next     = '0;
      release_next = 1'b1;
    end else begin
      case (state)
        RELEASED: begin
          if (rise) begin
            state_next = PRESSED;
            hold_next  = '0;
            press_next = 1'b1;
          end
        end
        PRESSED: begin
          if (!i_Repeat_En) begin
            hold_next = '0;
          end else if (hold_count == HOLD_MAX) begin
            state_next  = REPEATING;
            hold_next   = '0;
            rep_next    = '0;
            repeat_next = 1'b1;
          end else begin
            hold_next = hold_count + HOLD_W'(1);
          end
        end
        REPEATING: begin
          if (!i_Repeat_En) begin
            state_next = PRESSED;
            hold_next  = '0;
            rep_next   = '0;
          end else if (rep_count == REP_MAX) begin
            rep_next    = '0;
            repeat_next = 1'b1;
          end else begin
            rep_next = rep_count + REP_W'(1);
          end
        end
        default: begin
          state_next = RELEASED;
          hold_next  = '0;
          rep_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_step_conditioner.sv
// ---------------------------------------------------------------------------
// tb_switch_step_conditioner
//
// Directed bench for switch_step_conditioner with DEBOUNCE_LIMIT=4,
// HOLD_LIMIT=10, REPEAT_LIMIT=3. Each scenario runs a window of cycles,
// sampling 1 time unit after every rising edge; sample index c refers to
// the edge that follows the input update made at iteration c.
// ---------------------------------------------------------------------------
module tb_switch_step_conditioner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sw    = 1'b0;
  logic en    = 1'b0;
  logic o_switch;
  logic o_press;
  logic o_release;
  logic o_repeat;
  logic o_step;

  int checks = 0;
  int errors = 0;

  int press_n;
  int release_n;
  int repeat_n;
  int step_n;
  int sw_high;
  int press_at;
  int release_at;
  int release_pulse;
  int rep_at[16];
  int step_bad = 0;
  int excl_bad = 0;
  int adj_bad  = 0;

  switch_step_conditioner #(
    .DEBOUNCE_LIMIT(4),
    .HOLD_LIMIT    (10),
    .REPEAT_LIMIT  (3)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch   (sw),
    .i_Repeat_En(en),
    .o_Switch   (o_switch),
    .o_Press    (o_press),
    .o_Release  (o_release),
    .o_Repeat   (o_repeat),
    .o_Step     (o_step)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Runs one window: switch held high from iteration 0 until low_at (or the
  // bounce pattern for the first six iterations), repeat enable dropped and
  // raised at the given iterations. Records pulse counts and positions.
  task automatic applyStimulus(input int cycles, input int low_at, input logic en_init,
                               input int drop_at, input int raise_at, input logic bounce);
    logic [5:0] bp;
    logic       prev_step;
    bp            = 6'b101101;
    prev_step     = 1'b0;
    press_n       = 0;
    release_n     = 0;
    repeat_n      = 0;
    step_n        = 0;
    sw_high       = 0;
    press_at      = -1;
    release_at    = -1;
    release_pulse = -1;
    for (int i = 0; i < 16; i++) rep_at[i] = -1;
    en = en_init;
    for (int c = 0; c < cycles; c++) begin
      if (bounce && c < 6) sw = bp[3'(c)];
      else if (c >= low_at) sw = 1'b0;
      else sw = 1'b1;
      if (c == drop_at)  en = 1'b0;
      if (c == raise_at) en = 1'b1;
      @(posedge clk);
      #1;
      if (o_switch) sw_high++;
      if (o_press) begin
        if (press_at < 0) press_at = c;
        press_n++;
      end
      if (o_release) begin
        if (release_at < 0) begin
          release_at    = c;
          release_pulse = int'(o_repeat | o_step);
        end
        release_n++;
      end
      if (o_repeat) begin
        if (repeat_n < 16) rep_at[repeat_n] = c;
        repeat_n++;
      end
      if (o_step) step_n++;
      if (o_step != (o_press | o_repeat)) step_bad++;
      if ((int'(o_press) + int'(o_release) + int'(o_repeat)) > 1) excl_bad++;
      if (o_step && prev_step) adj_bad++;
      prev_step = o_step;
    end
  endtask

  initial begin
    int lat;
    int rel_seen;

    // Reset state
    #12;
    checkOutput("reset_switch",  int'(o_switch),  0);
    checkOutput("reset_press",   int'(o_press),   0);
    checkOutput("reset_release", int'(o_release), 0);
    checkOutput("reset_repeat",  int'(o_repeat),  0);
    checkOutput("reset_step",    int'(o_step),    0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Clean press and release, repeat disabled
    $display("[TB] clean press/release");
    applyStimulus(40, 20, 1'b0, -1, -1, 1'b0);
    checkOutput("clean_press_n",    press_n,    1);
    checkOutput("clean_press_at",   press_at,   5);
    checkOutput("clean_release_n",  release_n,  1);
    checkOutput("clean_release_at", release_at, 25);
    checkOutput("clean_repeat_n",   repeat_n,   0);
    checkOutput("clean_step_n",     step_n,     1);
    checkOutput("clean_sw_high",    sw_high,    20);

    // Bounce 1,0,1,1,0,1 then steady high
    $display("[TB] bounce");
    applyStimulus(30, 18, 1'b0, -1, -1, 1'b1);
    checkOutput("bounce_press_n",    press_n,    1);
    checkOutput("bounce_press_at",   press_at,   10);
    checkOutput("bounce_release_at", release_at, 23);
    checkOutput("bounce_sw_high",    sw_high,    13);

    // Auto-repeat held 30 cycles after the press
    $display("[TB] auto-repeat");
    applyStimulus(45, 30, 1'b1, -1, -1, 1'b0);
    checkOutput("rep_press_at", press_at, 5);
    checkOutput("rep_count",    repeat_n, 7);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("rep_at_%0d", i), rep_at[i], 15 + 3 * i);
    checkOutput("rep_step_n",     step_n,     8);
    checkOutput("rep_release_at", release_at, 35);

    // Repeat disabled after the first repeat, re-enabled later
    $display("[TB] repeat disable/re-enable");
    applyStimulus(48, 34, 1'b1, 16, 22, 1'b0);
    checkOutput("dis_count",      repeat_n,  4);
    checkOutput("dis_rep0",       rep_at[0], 15);
    checkOutput("dis_rep1",       rep_at[1], 31);
    checkOutput("dis_rep2",       rep_at[2], 34);
    checkOutput("dis_rep3",       rep_at[3], 37);
    checkOutput("dis_step_n",     step_n,    5);
    checkOutput("dis_release_at", release_at, 39);

    // Release landing on the edge a repeat is due
    $display("[TB] release coincident with repeat");
    applyStimulus(50, 31, 1'b1, -1, -1, 1'b0);
    checkOutput("coin_release_at",    release_at,    36);
    checkOutput("coin_release_pulse", release_pulse, 0);
    checkOutput("coin_repeat_n",      repeat_n,      7);
    checkOutput("coin_last_rep",      rep_at[6],     33);
    checkOutput("coin_step_n",        step_n,        8);
    checkOutput("coin_switch_end",    int'(o_switch), 0);

    // Reset asserted mid-press, then requalification
    $display("[TB] reset mid-press");
    sw = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("pre_reset_switch", int'(o_switch), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_switch",  int'(o_switch),  0);
    checkOutput("async_press",   int'(o_press),   0);
    checkOutput("async_release", int'(o_release), 0);
    checkOutput("async_repeat",  int'(o_repeat),  0);
    checkOutput("async_step",    int'(o_step),    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1;
    rel_seen = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (o_release) rel_seen++;
      if (o_press) begin
        lat = n;
        break;
      end
    end
    checkOutput("reset_press_latency", lat,            6);
    checkOutput("reset_no_release",    rel_seen,       0);
    checkOutput("reset_switch_after",  int'(o_switch), 1);

    // Invariants gathered over all windows
    checkOutput("step_equals_or", step_bad, 0);
    checkOutput("pulse_exclusive", excl_bad, 0);
    checkOutput("step_not_adjacent", adj_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
